// File: rtl/rv32i_types.sv
// Shared types for the memory arbiter: FSM state encoding and the latched request.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester round-robin memory arbiter with a busy-cycle timeout.
// A granted request is latched and held on the memory port until m_resp
// or the timeout fires; the one-cycle IDLE gap between transactions is inherent.
module mem_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] r0_addr,
  input  logic [3:0]  r0_rmask,
  input  logic [3:0]  r0_wmask,
  input  logic [31:0] r0_wdata,
  output logic [31:0] r0_rdata,
  output logic        r0_resp,
  input  logic [31:0] r1_addr,
  input  logic [3:0]  r1_rmask,
  input  logic [3:0]  r1_wmask,
  input  logic [31:0] r1_wdata,
  output logic [31:0] r1_rdata,
  output logic        r1_resp,
  output logic [31:0] m_addr,
  output logic [3:0]  m_rmask,
  output logic [3:0]  m_wmask,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_resp,
  output logic        err
);

  arb_state_t  state;
  mem_req_t    req_q;
  logic        last_grant;  // index of the requester granted most recently
  logic [15:0] busy_cnt;

  logic     r0_act, r1_act, grant_r1;
  logic     busy, timeout, done;
  mem_req_t r0_req, r1_req;

  // Request decode, priority pick and completion/timeout conditions
  always_comb begin
    r0_act   = (|r0_rmask) | (|r0_wmask);
    r1_act   = (|r1_rmask) | (|r1_wmask);
    r0_req   = '{addr: r0_addr, rmask: r0_rmask, wmask: r0_wmask, wdata: r0_wdata};
    r1_req   = '{addr: r1_addr, rmask: r1_rmask, wmask: r1_wmask, wdata: r1_wdata};
    // r1 wins when alone, or when both are active and r0 was granted last
    grant_r1 = r1_act && (!r0_act || !last_grant);
    busy     = (state != IDLE);
    timeout  = busy && !m_resp && (busy_cnt == 16'(TIMEOUT - 1));
    done     = busy && (m_resp || timeout);
  end

  // Arbitration FSM: grant in IDLE, hold the latched request until done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_q      <= '0;
      last_grant <= 1'b1;
      busy_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (r0_act || r1_act) begin
            req_q      <= grant_r1 ? r1_req : r0_req;
            last_grant <= grant_r1;
            state      <= grant_r1 ? BUSY1 : BUSY0;
            busy_cnt   <= '0;
          end
        end
        default: begin
          if (done) begin
            state <= IDLE;
          end else begin
            busy_cnt <= busy_cnt + 16'd1;
          end
        end
      endcase
    end
  end

  // Memory port and requester returns; everything is gated by the state so
  // reset clears the outputs without waiting for a clock edge
  always_comb begin
    m_addr   = busy ? req_q.addr  : '0;
    m_rmask  = busy ? req_q.rmask : '0;
    m_wmask  = busy ? req_q.wmask : '0;
    m_wdata  = busy ? req_q.wdata : '0;
    r0_resp  = (state == BUSY0) && done;
    r1_resp  = (state == BUSY1) && done;
    r0_rdata = ((state == BUSY0) && m_resp) ? m_rdata : '0;
    r1_rdata = ((state == BUSY1) && m_resp) ? m_rdata : '0;
    err      = timeout;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: per-cycle reference model plus directed scenarios.
module tb_mem_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] r0_addr = '0, r1_addr = '0, r0_wdata = '0, r1_wdata = '0;
  logic [3:0]  r0_rmask = '0, r0_wmask = '0, r1_rmask = '0, r1_wmask = '0;
  logic [31:0] r0_rdata, r1_rdata;
  logic        r0_resp, r1_resp;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_rmask, m_wmask;
  logic [31:0] m_rdata = '0;
  logic        m_resp = 1'b0;
  logic        err;

  int errors = 0;
  int checks = 0;

  // responder controls (driver writes, responder reads)
  int          lat = 1;           // 0 = never respond
  logic [31:0] mem_data = '0;
  bit          idle_pulse = 0;

  // completion events observed on the DUT
  int          ev_who[$];
  logic [31:0] ev_rdata[$], ev_addr[$], ev_wdata[$];
  bit          ev_err[$];
  logic [31:0] last_addr, last_wdata;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .r0_addr(r0_addr), .r0_rmask(r0_rmask), .r0_wmask(r0_wmask), .r0_wdata(r0_wdata),
    .r0_rdata(r0_rdata), .r0_resp(r0_resp),
    .r1_addr(r1_addr), .r1_rmask(r1_rmask), .r1_wmask(r1_wmask), .r1_wdata(r1_wdata),
    .r1_rdata(r1_rdata), .r1_resp(r1_resp),
    .m_addr(m_addr), .m_rmask(m_rmask), .m_wmask(m_wmask), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_resp(m_resp), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory responder: pulses m_resp in the lat-th cycle a request is presented
  initial begin : responder
    int bc;
    bc = 0;
    forever begin
      @(posedge clk);
      #2;
      if (rst || (m_rmask == 4'h0 && m_wmask == 4'h0)) begin
        bc     = 0;
        m_resp = idle_pulse && !rst;
      end else begin
        bc++;
        m_resp  = (lat != 0) && (bc == lat);
        m_rdata = mem_data;
      end
    end
  end

  // Reference model: who owns the memory, what it latched, how long it has waited
  initial begin : scoreboard
    int          owner, age, last, pick;
    logic [31:0] q_addr, q_wdata, e_addr, e_wdata, e_r0d, e_r1d;
    logic [3:0]  q_rm, q_wm, e_rm, e_wm;
    bit          fin_ok, fin_to, a0, a1;
    owner = -1; age = 0; last = 1;
    q_addr = '0; q_wdata = '0; q_rm = '0; q_wm = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        owner = -1; age = 0; last = 1;
        q_addr = '0; q_wdata = '0; q_rm = '0; q_wm = '0;
      end
      fin_ok  = (owner >= 0) && m_resp;
      fin_to  = (owner >= 0) && !m_resp && (age == TO - 1);
      e_addr  = (owner >= 0) ? q_addr  : 32'h0;
      e_wdata = (owner >= 0) ? q_wdata : 32'h0;
      e_rm    = (owner >= 0) ? q_rm    : 4'h0;
      e_wm    = (owner >= 0) ? q_wm    : 4'h0;
      e_r0d   = (owner == 0 && fin_ok) ? m_rdata : 32'h0;
      e_r1d   = (owner == 1 && fin_ok) ? m_rdata : 32'h0;
      check("m_addr",   m_addr,  e_addr);
      check("m_wdata",  m_wdata, e_wdata);
      check("m_rmask",  32'(m_rmask), 32'(e_rm));
      check("m_wmask",  32'(m_wmask), 32'(e_wm));
      check("r0_resp",  32'(r0_resp), 32'(owner == 0 && (fin_ok || fin_to)));
      check("r1_resp",  32'(r1_resp), 32'(owner == 1 && (fin_ok || fin_to)));
      check("r0_rdata", r0_rdata, e_r0d);
      check("r1_rdata", r1_rdata, e_r1d);
      check("err",      32'(err), 32'(fin_to));
      if (!rst) begin
        if (fin_ok || fin_to) begin
          ev_who.push_back(owner);
          ev_rdata.push_back(owner == 0 ? r0_rdata : r1_rdata);
          ev_err.push_back(err);
          ev_addr.push_back(m_addr);
          ev_wdata.push_back(m_wdata);
          owner = -1;
        end else if (owner >= 0) begin
          age++;
        end else begin
          a0 = (r0_rmask != 0) || (r0_wmask != 0);
          a1 = (r1_rmask != 0) || (r1_wmask != 0);
          if (a0 && a1)  pick = (last == 0) ? 1 : 0;
          else if (a0)   pick = 0;
          else if (a1)   pick = 1;
          else           pick = -1;
          if (pick == 0) begin
            q_addr = r0_addr; q_wdata = r0_wdata; q_rm = r0_rmask; q_wm = r0_wmask;
          end else if (pick == 1) begin
            q_addr = r1_addr; q_wdata = r1_wdata; q_rm = r1_rmask; q_wm = r1_wmask;
          end
          if (pick >= 0) begin
            owner = pick; last = pick; age = 0;
          end
        end
      end
    end
  end

  // Waits (bounded) for the next completion and checks it against literals
  task automatic expect_event(input string name, input int who, input logic [31:0] rdata,
                              input bit e, output int n);
    n = 0;
    while (ev_who.size() == 0 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (ev_who.size() == 0) begin
      errors++;
      $display("FAIL %s: no completion within 40 cycles", name);
    end else begin
      check({name, " who"},   32'(ev_who.pop_front()), 32'(who));
      check({name, " rdata"}, ev_rdata.pop_front(), rdata);
      check({name, " err"},   32'(ev_err.pop_front()), 32'(e));
      last_addr  = ev_addr.pop_front();
      last_wdata = ev_wdata.pop_front();
    end
  endtask

  initial begin : driver
    int n;
    // reset state
    repeat (2) step();
    check("reset m_rmask", 32'(m_rmask), 32'h0);
    check("reset r0_resp", 32'(r0_resp), 32'h0);
    rst = 1'b0;
    step();

    // single read, response in the 3rd busy cycle
    lat = 3; mem_data = 32'hdeadbeef;
    r0_addr = 32'h1eceb000; r0_rmask = 4'hF;
    step();
    #3;
    check("read m_rmask next cycle", 32'(m_rmask), 32'hF);
    check("read m_addr", m_addr, 32'h1eceb000);
    expect_event("single read", 0, 32'hdeadbeef, 1'b0, n);
    r0_rmask = '0;
    step();

    // simultaneous requests after a reset: r0 first, gap, then r1 write
    rst = 1'b1; step(); rst = 1'b0; step();
    lat = 2; mem_data = 32'h11112222;
    r0_addr = 32'h100; r0_rmask = 4'hF;
    r1_addr = 32'h200; r1_wmask = 4'h3; r1_wdata = 32'h0000abcd;
    expect_event("pair first", 0, 32'h11112222, 1'b0, n);
    check("pair first addr", last_addr, 32'h100);
    r0_rmask = '0;
    #3;
    check("gap rmask", 32'(m_rmask), 32'h0);
    check("gap wmask", 32'(m_wmask), 32'h0);
    expect_event("pair second", 1, 32'h11112222, 1'b0, n);
    check("pair second latency", 32'(n), 32'd3);
    check("pair second addr", last_addr, 32'h200);
    check("pair second wdata", last_wdata, 32'h0000abcd);
    r1_wmask = '0;
    step();

    // fairness: both held active for six transactions
    lat = 1; mem_data = 32'h0;
    r0_rmask = 4'hF; r1_rmask = 4'h1;
    for (int i = 0; i < 6; i++) expect_event("fair", i % 2, 32'h0, 1'b0, n);
    r0_rmask = '0; r1_rmask = '0;
    step();

    // timeout: r1 read never answered
    lat = 0; mem_data = 32'h12345678;
    r1_addr = 32'h40; r1_rmask = 4'hF;
    expect_event("timeout", 1, 32'h0, 1'b1, n);
    check("timeout cycle", 32'(n), 32'd5);
    r1_rmask = '0;
    #3;
    check("timeout idle rmask", 32'(m_rmask), 32'h0);
    step();

    // m_resp in the timeout cycle wins
    lat = 4; mem_data = 32'hcafef00d;
    r0_addr = 32'h80; r0_rmask = 4'h3;
    expect_event("tie", 0, 32'hcafef00d, 1'b0, n);
    check("tie cycle", 32'(n), 32'd5);
    r0_rmask = '0;
    step();

    // both masks forwarded, inputs dropped mid-transaction, stray m_resp in IDLE
    lat = 3; mem_data = 32'h0bad0bad;
    r1_addr = 32'h300; r1_rmask = 4'h5; r1_wmask = 4'hA; r1_wdata = 32'h55aa;
    step(); step();
    check("both masks r", 32'(m_rmask), 32'h5);
    check("both masks w", 32'(m_wmask), 32'hA);
    r1_rmask = '0; r1_wmask = '0; r1_addr = 32'hffff_fff0;
    expect_event("dropped", 1, 32'h0bad0bad, 1'b0, n);
    check("dropped addr", last_addr, 32'h300);
    idle_pulse = 1;
    step();
    idle_pulse = 0;
    repeat (2) step();
    check("idle m_resp ignored", 32'(ev_who.size()), 32'h0);

    // reset mid-BUSY0 (r1 would otherwise be preferred next)
    lat = 0;
    r0_addr = 32'h500; r0_rmask = 4'hF; r1_addr = 32'h600; r1_rmask = 4'hF;
    step(); step();
    #6;
    rst = 1'b1;
    #1;
    check("async rst rmask", 32'(m_rmask), 32'h0);
    check("async rst wmask", 32'(m_wmask), 32'h0);
    @(posedge clk); @(negedge clk); @(posedge clk);
    #1;
    rst = 1'b0;
    lat = 1; mem_data = 32'h77;
    expect_event("after reset", 0, 32'h77, 1'b0, n);
    check("after reset latency", 32'(n), 32'd2);
    check("after reset addr", last_addr, 32'h500);
    r0_rmask = '0; r1_rmask = '0;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 256, number of busy cycles without m_resp before the transaction is aborted (range 2..65535).
REQ-002 clk  input  1  clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 r0_addr / r1_addr  input  32  requester byte address, word-aligned (bits [1:0] = 0).
REQ-005 r0_rmask / r1_rmask  input  4  requester read byte mask; nonzero means a read request.
REQ-006 r0_wmask / r1_wmask  input  4  requester write byte mask; nonzero means a write request.
REQ-007 r0_wdata / r1_wdata  input  32  requester write data.
REQ-008 r0_rdata / r1_rdata  output  32  read data returned to the requester.
REQ-009 r0_resp / r1_resp  output  1  one-cycle completion pulse to the requester.
REQ-010 m_addr, m_rmask, m_wmask, m_wdata  output  32/4/4/32  shared memory request.
REQ-011 m_rdata  input  32  memory read data; m_resp  input  1  memory completion pulse.
REQ-012 err  output  1  one-cycle pulse when a transaction times out.

Function
REQ-013 A requester is active when its rmask or wmask is nonzero; requesters hold all request signals stable until their resp.
REQ-014 The FSM has three states: IDLE, BUSY0 and BUSY1.
REQ-015 IDLE, no active requester: stay in IDLE; m_rmask = m_wmask = 0; m_addr = m_wdata = 0.
REQ-016 IDLE, exactly one active requester: latch that requester's addr/rmask/wmask/wdata into the request register and go to BUSYn.
REQ-017 IDLE, both active: grant the requester that is not last_grant, latch it, and go to BUSYn.
REQ-018 last_grant updates on every grant.
REQ-019 In BUSYn, m_* is driven only from the request register; latency is one cycle from request seen in IDLE to m_* asserted.
REQ-020 In BUSYn with m_resp = 1: rn_resp = 1 in the same cycle, rn_rdata = m_rdata, masks stay asserted that cycle, and the FSM returns to IDLE next cycle.
REQ-021 Back-to-back transactions therefore have a one-cycle IDLE gap, and the masks are 0 during it.
REQ-022 The non-granted requester sees resp = 0 and rdata = 0 at all times.
REQ-023 Requester inputs that change or drop during BUSYn are ignored; the latched transaction completes and resp is still issued.
REQ-024 rmask and wmask both nonzero are forwarded unchanged, with no arbitration significance.
REQ-025 A 16-bit busy counter clears on entry to BUSYn and increments each BUSY cycle without m_resp.
REQ-026 When the counter reaches TIMEOUT-1 without m_resp, the arbiter aborts in that cycle: rn_resp = 1, rn_rdata = 0, err = 1, and the next state is IDLE.
REQ-027 When m_resp and timeout coincide, m_resp wins: normal completion and err = 0.
REQ-028 m_resp while in IDLE is ignored, with no resp and no err.

Reset
REQ-029 Asserting rst at any time, including mid-transaction, immediately forces: state IDLE, last_grant = 1 (r0 preferred first), counter 0, request register 0, and all outputs 0.
REQ-030 The first grant after reset deassertion goes no earlier than the first posedge with rst low.

Structure
REQ-031 The state enum (IDLE/BUSY0/BUSY1) and the packed request struct (addr, rmask, wmask, wdata) live in the shared package rv32i_types.
REQ-032 The design is a single module with no sub-module; the counter and the priority pick are inline.

Verification
REQ-033 Single read: r0_addr = 0x1eceb000, r0_rmask = 0xF; memory responds 3 cycles later with 0xdeadbeef -> m_rmask asserted the cycle after the request; r0_resp = 1 with r0_rdata = 0xdeadbeef; r1_resp = 0 throughout.
REQ-034 Simultaneous requests after reset: r0 read 0x100 and r1 write 0x200 (wmask 0x3, wdata 0x0000abcd) -> r0 is served first, then r1 after a one-cycle gap, with m_wdata = 0x0000abcd.
REQ-035 Fairness: both requesters held active for 6 transactions -> grant order r0, r1, r0, r1, r0, r1.
REQ-036 Timeout with TIMEOUT = 4: r1 read and m_resp never asserted -> r1_resp and err pulse together in the 4th BUSY cycle, r1_rdata = 0, FSM back in IDLE.
REQ-037 Timeout tie with TIMEOUT = 4: m_resp arrives exactly in the 4th BUSY cycle -> normal completion, err = 0.
REQ-038 Reset mid-BUSY0: rst asserted between clock edges -> m_rmask and m_wmask = 0 before the next edge; after release, r0 is granted first when both requesters are active.
